// File: rtl/pp_pipeline_accel_fifo2axis_x_pkg.sv
// Shared definitions for the FIFO-to-AXI4-Stream pipeline stages: the
// default widths and the FSM state encoding.
package pp_pipeline_accel_fifo2axis_x_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_DIM_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pp_pipeline_accel_fifo2axis_x_if.sv
// AXI4-Stream bundle carrying video-style lines: tlast marks end of line,
// tuser marks start of frame.
interface pp_pipeline_accel_fifo2axis_x_if
  import pp_pipeline_accel_fifo2axis_x_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tuser;
  logic                    tvalid;
  logic                    tready;

  modport master (
    output tdata, tkeep, tlast, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tuser, tvalid,
    output tready
  );

endinterface

// File: rtl/pp_pipeline_accel_fifo2axis_x_regslice.sv
// Single-entry output register slice. A load overwrites the slice; otherwise
// a consumer handshake empties it. tvalid is purely registered, so it never
// depends combinationally on tready.
module pp_pipeline_accel_fifo2axis_x_regslice
  import pp_pipeline_accel_fifo2axis_x_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_user,
  input  logic                  tready,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tlast,
  output logic                  tuser,
  output logic                  tvalid
);

  // Slice register: load new beat, hold while stalled, clear on handshake.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tlast  <= 1'b0;
      tuser  <= 1'b0;
    end else if (load_en) begin
      tvalid <= 1'b1;
      tdata  <= in_data;
      tlast  <= in_last;
      tuser  <= in_user;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/pp_pipeline_accel_fifo2axis_x.sv
// Streams rows x cols words from a FWFT FIFO onto AXI4-Stream with
// start-of-frame (tuser) and end-of-line (tlast) sideband, under an
// ap_start/ap_ready/ap_idle/ap_done block-level handshake.
module pp_pipeline_accel_fifo2axis_x
  import pp_pipeline_accel_fifo2axis_x_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DIM_WIDTH  = DEFAULT_DIM_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [DIM_WIDTH-1:0]  rows,
  input  logic [DIM_WIDTH-1:0]  cols,
  input  logic                  if_empty_n,
  output logic                  if_read,
  input  logic [DATA_WIDTH-1:0] if_dout,
  pp_pipeline_accel_fifo2axis_x_if.master m_axis
);

  localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

  state_t                  state, state_next;
  logic [DIM_WIDTH-1:0]    rows_q, cols_q;
  logic [DIM_WIDTH-1:0]    row_cnt, col_cnt;
  logic                    start_acc;
  logic                    dims_zero;
  logic                    last_col, last_row;
  logic                    load_en;
  logic                    slice_valid;
  logic                    slice_last, slice_user;
  logic [DATA_WIDTH-1:0]   slice_data;

  // Counters only reach these comparisons in RUN, where rows_q/cols_q >= 1,
  // so the subtraction never wraps.
  assign start_acc = (state == IDLE) && ap_start && !reset;
  assign dims_zero = (rows == '0) || (cols == '0);
  assign last_col  = (col_cnt == cols_q - DIM_ONE);
  assign last_row  = (row_cnt == rows_q - DIM_ONE);
  assign load_en   = !reset && (state == RUN) && if_empty_n &&
                     (!slice_valid || m_axis.tready);

  assign if_read  = load_en;
  assign ap_ready = start_acc;
  assign ap_idle  = (state == IDLE) || reset;
  assign ap_done  = (state == DONE) && !reset;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_acc) state_next = dims_zero ? DONE : RUN;
      RUN:     if (load_en && last_col && last_row) state_next = DRAIN;
      DRAIN:   if (slice_valid && m_axis.tready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame dimensions are captured only when a start is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_q <= '0;
      cols_q <= '0;
    end else if (start_acc) begin
      rows_q <= rows;
      cols_q <= cols;
    end
  end

  // Column/row position of the next word to load; advance only on a load.
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (load_en) begin
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + DIM_ONE;
      end else begin
        col_cnt <= col_cnt + DIM_ONE;
      end
    end
  end

  pp_pipeline_accel_fifo2axis_x_regslice #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regslice (
    .clk     (clk),
    .reset   (reset),
    .load_en (load_en),
    .in_data (if_dout),
    .in_last (last_col),
    .in_user ((row_cnt == '0) && (col_cnt == '0)),
    .tready  (m_axis.tready),
    .tdata   (slice_data),
    .tlast   (slice_last),
    .tuser   (slice_user),
    .tvalid  (slice_valid)
  );

  assign m_axis.tdata  = slice_data;
  assign m_axis.tlast  = slice_last;
  assign m_axis.tuser  = slice_user;
  assign m_axis.tvalid = slice_valid;
  assign m_axis.tkeep  = '1;

endmodule

// File: tb/tb_pp_pipeline_accel_fifo2axis_x.sv
// Scoreboard bench for pp_pipeline_accel_fifo2axis_x: stimulus pushes
// expected beats and done tokens; a negedge monitor pops and compares.
module tb_pp_pipeline_accel_fifo2axis_x;
  import pp_pipeline_accel_fifo2axis_x_pkg::*;

  localparam int DW = 64;
  localparam int AW = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ap_start = 1'b0;
  wire           ap_ready, ap_idle, ap_done;
  logic [AW-1:0] rows = '0, cols = '0;
  logic          if_empty_n;
  wire           if_read;
  logic [DW-1:0] if_dout;

  always #5 clk = ~clk;

  pp_pipeline_accel_fifo2axis_x_if #(.DATA_WIDTH(DW)) axis ();

  pp_pipeline_accel_fifo2axis_x #(.DATA_WIDTH(DW), .DIM_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ap_start   (ap_start),
    .ap_ready   (ap_ready),
    .ap_idle    (ap_idle),
    .ap_done    (ap_done),
    .rows       (rows),
    .cols       (cols),
    .if_empty_n (if_empty_n),
    .if_read    (if_read),
    .if_dout    (if_dout),
    .m_axis     (axis)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // FWFT FIFO model
  logic [DW-1:0] mem [0:63];
  logic [6:0]    rd_idx = '0;
  int            wr_cnt = 0;
  logic          hold_empty = 1'b0;
  assign if_empty_n = (int'(rd_idx) < wr_cnt) && !hold_empty;
  assign if_dout    = mem[rd_idx[5:0]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) rd_idx <= '0;
    else if (if_read) rd_idx <= rd_idx + 7'd1;
  end

  // tready driver: mode 1 applies the 1,0,0,1 pattern
  int         tready_mode = 0;
  logic [3:0] pat = 4'b1001;
  always @(posedge clk) begin
    #2;
    axis.tready = (tready_mode == 1) ? pat[cyc[1:0]] : 1'b1;
  end

  beat_t exp_q[$];
  int    done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  int            hs_total = 0, done_total = 0, ready_cnt = 0, tv_cycles = 0;
  int            hs_cyc [64];
  int            done_cyc [64];
  int            ready_cyc [64];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last, prev_user;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(axis.tvalid), 64'd1);
        check("hold_data", axis.tdata, prev_data);
        check("hold_last", 64'(axis.tlast), 64'(prev_last));
        check("hold_user", 64'(axis.tuser), 64'(prev_user));
      end
      if (axis.tvalid) tv_cycles++;
      if (axis.tvalid && axis.tready) begin
        if (hs_total < 64) hs_cyc[hs_total] = cyc;
        hs_total++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got data %0h, expected none", axis.tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", axis.tdata, e.data);
          check("beat_last", 64'(axis.tlast), 64'(e.last));
          check("beat_user", 64'(axis.tuser), 64'(e.user));
          check("beat_keep", 64'(axis.tkeep), 64'hFF);
        end
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
      prev_user  = axis.tuser;
      if (ap_ready) begin
        if (ready_cnt < 64) ready_cyc[ready_cnt] = cyc;
        ready_cnt++;
      end
      if (ap_done) begin
        if (done_total < 64) done_cyc[done_total] = cyc;
        done_total++;
        tests++;
        if (done_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got ap_done, expected none (cyc %0d)", cyc);
        end else begin
          void'(done_q.pop_front());
        end
      end
    end
  end

  // Fill FIFO and push expected beats plus one done token
  task automatic load_frame(input int r, input int c, input logic [DW-1:0] base);
    for (int i = 0; i < r * c; i++) begin
      beat_t b;
      mem[wr_cnt + i] = base + DW'(i);
      b.data = base + DW'(i);
      b.user = (i == 0);
      b.last = ((i % c) == c - 1);
      exp_q.push_back(b);
    end
    wr_cnt += r * c;
    done_q.push_back(1);
  endtask

  task automatic start_frame(input int r, input int c);
    @(posedge clk); #2;
    rows = AW'(r); cols = AW'(c); ap_start = 1'b1;
    @(negedge clk);
    check("start_ready", 64'(ap_ready), 64'd1);
    check("start_idle", 64'(ap_idle), 64'd1);
    @(posedge clk); #2;
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_total < target && n < budget) begin
      @(posedge clk); #2; n++;
    end
    check("done_timeout", 64'(done_total >= target), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, h0, r0, t0, n;
    // Reset state, with ap_start high to confirm it is ignored under reset
    ap_start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ap_ready), 64'd0);
    check("rst_idle", 64'(ap_idle), 64'd1);
    check("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("rst_read", 64'(if_read), 64'd0);
    check("rst_done", 64'(ap_done), 64'd0);
    check("rst_tdata", axis.tdata, 64'd0);
    check("rst_tlast", 64'(axis.tlast), 64'd0);
    check("rst_tuser", 64'(axis.tuser), 64'd0);
    @(posedge clk); #2;
    ap_start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 64'(ap_idle), 64'd1);

    // 2x3 frame at full rate
    d0 = done_total; h0 = hs_total; r0 = int'(rd_idx);
    load_frame(2, 3, 64'd0);
    start_frame(2, 3);
    wait_done(d0 + 1, 100);
    check("t1_reads", 64'(int'(rd_idx) - r0), 64'd6);
    check("t1_span", 64'(hs_cyc[h0 + 5] - hs_cyc[h0]), 64'd5);
    check("t1_done_lat", 64'(done_cyc[d0] - hs_cyc[h0 + 5]), 64'd1);

    // Same frame under tready 1,0,0,1 backpressure
    tready_mode = 1;
    d0 = done_total; r0 = int'(rd_idx);
    load_frame(2, 3, 64'h10);
    start_frame(2, 3);
    wait_done(d0 + 1, 200);
    check("t2_reads", 64'(int'(rd_idx) - r0), 64'd6);
    tready_mode = 0;
    @(posedge clk); #2;

    // 1x4 frame with FIFO empty for 3 cycles after the first word
    d0 = done_total; r0 = int'(rd_idx);
    load_frame(1, 4, 64'h20);
    start_frame(1, 4);
    n = 0;
    while (int'(rd_idx) != r0 + 1 && n < 20) begin
      @(posedge clk); #2; n++;
    end
    check("t3_first_read", 64'(int'(rd_idx) - r0), 64'd1);
    hold_empty = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t3_tvalid_drop", 64'(axis.tvalid), 64'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("t3_no_read", 64'(int'(rd_idx) - r0), 64'd1);
    hold_empty = 1'b0;
    wait_done(d0 + 1, 100);
    check("t3_reads", 64'(int'(rd_idx) - r0), 64'd4);

    // Zero-row frame: ready and done, nothing else
    d0 = done_total; r0 = int'(rd_idx); t0 = tv_cycles;
    done_q.push_back(1);
    start_frame(0, 5);
    wait_done(d0 + 1, 20);
    repeat (3) @(posedge clk);
    #2;
    check("t4_reads", 64'(int'(rd_idx) - r0), 64'd0);
    check("t4_tvalid", 64'(tv_cycles - t0), 64'd0);

    // Reset after beat 2 of a 4x4 frame, then a full frame
    h0 = hs_total;
    load_frame(4, 4, 64'h100);
    start_frame(4, 4);
    n = 0;
    while (hs_total < h0 + 3 && n < 50) begin
      @(posedge clk); #2; n++;
    end
    check("t5_three_beats", 64'(hs_total - h0), 64'd3);
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    wr_cnt = 0;
    @(posedge clk); #2;
    reset = 1'b0;
    d0 = done_total;
    @(negedge clk);
    check("t5_tvalid", 64'(axis.tvalid), 64'd0);
    check("t5_idle", 64'(ap_idle), 64'd1);
    repeat (5) @(posedge clk);
    #2;
    check("t5_no_done", 64'(done_total - d0), 64'd0);
    r0 = int'(rd_idx);
    load_frame(4, 4, 64'h200);
    start_frame(4, 4);
    wait_done(d0 + 1, 200);
    check("t5_reads", 64'(int'(rd_idx) - r0), 64'd16);

    // ap_start held high: second frame starts only after done + IDLE
    d0 = done_total; t0 = ready_cnt;
    load_frame(1, 2, 64'h300);
    load_frame(1, 2, 64'h310);
    @(posedge clk); #2;
    rows = AW'(1); cols = AW'(2); ap_start = 1'b1;
    n = 0;
    while (done_total < d0 + 2 && n < 100) begin
      @(posedge clk); #2; n++;
    end
    ap_start = 1'b0;
    check("t6_dones", 64'(done_total - d0), 64'd2);
    check("t6_readies", 64'(ready_cnt - t0), 64'd2);
    check("t6_restart_gap", 64'(ready_cyc[t0 + 1] - done_cyc[d0]), 64'd1);

    repeat (5) @(posedge clk);
    #2;
    check("left_beats", 64'(exp_q.size()), 64'd0);
    check("left_dones", 64'(done_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
